// File: rtl/valu_slot_dispatch_pkg.sv
// Shared types for the vector-ALU issue path.
// Contents: the decoded instruction and ALU control word handed to the
// slots, the buffered dispatch entry, and is_serialized(). is_serialized()
// flags instructions that must run alone: vector stores and reductions.
package rvvLitePkg;

  typedef enum logic [3:0] {
    VALU_ADD = 4'd0,
    VALU_SUB = 4'd1,
    VALU_AND = 4'd2,
    VALU_OR  = 4'd3,
    VALU_XOR = 4'd4,
    VALU_MIN = 4'd5,
    VALU_MAX = 4'd6
  } valu_op_e;

  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [5:0] funct6;
    logic [4:0] vd;
    logic [4:0] vs1;
    logic [4:0] vs2;
    logic [7:0] vl;
    logic       is_vStore;
  } decoded_vinstruction_t;

  typedef struct packed {
    valu_op_e   alu_op;
    logic       vAdd_en;
    logic       vRedAndOrXor_en;
    logic       vRedSum_min_max_en;
    logic [1:0] sew;
  } valu_ctrl_t;

  typedef struct packed {
    decoded_vinstruction_t instr;
    valu_ctrl_t            ctrl;
    logic                  ser;
  } vdispatch_entry_t;

  // Stores and reductions touch shared state, so they may not overlap
  // with any other slot activity.
  function automatic logic is_serialized(input decoded_vinstruction_t instr,
                                         input valu_ctrl_t ctrl);
    return instr.is_vStore | ctrl.vRedAndOrXor_en | ctrl.vRedSum_min_max_en;
  endfunction

endpackage

// File: rtl/valu_slot_dispatch_fifo.sv
// vDispatchFifo: in-order synchronous FIFO of dispatch entries.
// Ports: clk, rst (sync, active-low), push/push_data, pop, head (entry at
// read pointer), full, empty, count. The caller never pushes when full
// nor pops when empty. A push and a pop in one cycle leave count unchanged.
module vDispatchFifo
  import rvvLitePkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  vdispatch_entry_t           push_data,
  input  logic                       pop,
  output vdispatch_entry_t           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  vdispatch_entry_t mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;

  // Storage array; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == CW'(0));

endmodule

// File: rtl/valu_slot_dispatch.sv
// valu_slot_dispatch: issue stage in front of the vector-ALU slots.
// Ports:
//   clk, rst (sync, active-low)
//   in_valid/in_ready/in_instr/in_ctrl : upstream handshake into the buffer
//   stall                              : blocks any new issue
//   slot_active                        : per-slot busy indication
//   slot_init                          : one-cycle one-hot start pulse
//   slot_instr/slot_ctrl               : broadcast payload, valid with slot_init
//   idle                               : nothing buffered, pending or running
//   issued_count                       : issues since reset (wraps)
// The head entry goes to the first free slot at or after the round-robin
// pointer. Stores and reductions wait for every slot to be free. While one
// runs, ser_busy holds back all younger instructions.
module valu_slot_dispatch
  import rvvLitePkg::*;
#(
  parameter int SLOT_COUNT = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  decoded_vinstruction_t in_instr,
  input  valu_ctrl_t            in_ctrl,
  input  logic                  stall,
  input  logic [SLOT_COUNT-1:0] slot_active,
  output logic [SLOT_COUNT-1:0] slot_init,
  output decoded_vinstruction_t slot_instr,
  output valu_ctrl_t            slot_ctrl,
  output logic                  idle,
  output logic [31:0]           issued_count
);

  localparam int SW = (SLOT_COUNT > 1) ? $clog2(SLOT_COUNT) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  vdispatch_entry_t       push_entry_s;
  vdispatch_entry_t       head_s;
  logic                   push_s;
  logic                   issue_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic [CW-1:0]          fifo_count_s;
  logic [SLOT_COUNT-1:0]  free_s;
  logic                   all_free_s;
  logic                   sel_found_s;
  logic [SW-1:0]          sel_idx_s;
  logic [SW-1:0]          rr_next_s;
  logic [SLOT_COUNT-1:0]  sel_onehot_s;
  int                     cand_idx_s;

  logic                   ready_en_r;
  logic [SLOT_COUNT-1:0]  slot_init_r;
  decoded_vinstruction_t  slot_instr_r;
  valu_ctrl_t             slot_ctrl_r;
  logic [SW-1:0]          rr_ptr_r;
  logic                   ser_busy_r;
  logic [SW-1:0]          ser_slot_r;
  logic [31:0]            issued_count_r;

  assign push_entry_s = '{instr: in_instr, ctrl: in_ctrl,
                          ser: is_serialized(in_instr, in_ctrl)};
  // ready_en_r keeps in_ready low through reset and the edge that leaves it.
  assign in_ready = ready_en_r & ~fifo_full_s;
  assign push_s   = in_valid & in_ready;

  vDispatchFifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (issue_s),
    .head      (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // A slot still showing its init pulse has not raised active yet,
  // so it counts as busy too.
  assign free_s     = ~slot_active & ~slot_init_r;
  assign all_free_s = &free_s;

  // Round-robin pick: first free slot scanning upward from rr_ptr_r, wrapping.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    cand_idx_s  = 0;
    for (int k = 0; k < SLOT_COUNT; k++) begin
      cand_idx_s = (int'(rr_ptr_r) + k) % SLOT_COUNT;
      if (!sel_found_s && free_s[cand_idx_s]) begin
        sel_found_s = 1'b1;
        sel_idx_s   = SW'(cand_idx_s);
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  assign sel_onehot_s = SLOT_COUNT'(1) << sel_idx_s;
  assign rr_next_s    = (sel_idx_s == SW'(SLOT_COUNT - 1)) ? '0 : sel_idx_s + SW'(1);

  assign issue_s = ~fifo_empty_s & ~stall & ~ser_busy_r & sel_found_s &
                   (~head_s.ser | all_free_s);

  // Issue registers, round-robin pointer, serialization tracking, counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ready_en_r     <= 1'b0;
      slot_init_r    <= '0;
      slot_instr_r   <= '0;
      slot_ctrl_r    <= '0;
      rr_ptr_r       <= '0;
      ser_busy_r     <= 1'b0;
      ser_slot_r     <= '0;
      issued_count_r <= 32'd0;
    end else begin
      ready_en_r <= 1'b1;
      if (issue_s) begin
        slot_init_r    <= sel_onehot_s;
        slot_instr_r   <= head_s.instr;
        slot_ctrl_r    <= head_s.ctrl;
        rr_ptr_r       <= rr_next_s;
        issued_count_r <= issued_count_r + 32'd1;
      end else begin
        slot_init_r <= '0;
      end
      // issue_s implies ser_busy_r is low, so set and clear never collide.
      if (issue_s && head_s.ser) begin
        ser_busy_r <= 1'b1;
        ser_slot_r <= sel_idx_s;
      end else if (ser_busy_r && !slot_init_r[ser_slot_r] && !slot_active[ser_slot_r]) begin
        ser_busy_r <= 1'b0;
      end
    end
  end

  assign slot_init    = slot_init_r;
  assign slot_instr   = slot_instr_r;
  assign slot_ctrl    = slot_ctrl_r;
  assign issued_count = issued_count_r;
  assign idle         = fifo_empty_s & ~(|slot_init_r) & ~(|slot_active) & ~ser_busy_r;

endmodule

// File: tb/tb_valu_slot_dispatch.sv
module tb_valu_slot_dispatch;
  import rvvLitePkg::*;

  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  decoded_vinstruction_t in_instr;
  valu_ctrl_t            in_ctrl;
  logic                  stall;
  logic [1:0]            slot_active;
  logic [1:0]            slot_init;
  decoded_vinstruction_t slot_instr;
  valu_ctrl_t            slot_ctrl;
  logic                  idle;
  logic [31:0]           issued_count;

  int checks = 0;
  int errors = 0;

  valu_slot_dispatch #(.SLOT_COUNT(2), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_ctrl      (in_ctrl),
    .stall        (stall),
    .slot_active  (slot_active),
    .slot_init    (slot_init),
    .slot_instr   (slot_instr),
    .slot_ctrl    (slot_ctrl),
    .idle         (idle),
    .issued_count (issued_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic decoded_vinstruction_t mk_instr(input logic [4:0] vd, input logic st);
    decoded_vinstruction_t r;
    r = '0;
    r.opcode    = st ? 7'h27 : 7'h57;
    r.vd        = vd;
    r.vs1       = 5'd1;
    r.vs2       = 5'd2;
    r.vl        = 8'd8;
    r.is_vStore = st;
    return r;
  endfunction

  function automatic valu_ctrl_t mk_ctrl();
    valu_ctrl_t c;
    c = '0;
    c.alu_op  = VALU_ADD;
    c.vAdd_en = 1'b1;
    return c;
  endfunction

  // Inputs change right after a negedge; outputs are checked at negedges.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; stall = 1'b0; slot_active = 2'b00;
    in_instr = '0; in_ctrl = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; stall = 1'b0; slot_active = 2'b00;
    in_instr = '0; in_ctrl = '0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (slot_init !== 2'b00) begin errors++; $display("FAIL reset_init: got %b expected 00", slot_init); end
    checks++; if (slot_instr !== '0) begin errors++; $display("FAIL reset_instr: got %h expected 0", slot_instr); end
    checks++; if (slot_ctrl !== '0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", slot_ctrl); end
    checks++; if (issued_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", issued_count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", in_ready); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", idle); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b expected 1", in_ready); end
  endtask

  task automatic test_single();
    decoded_vinstruction_t a;
    a = mk_instr(5'd3, 1'b0);
    do_reset();
    for (int k = 0; k <= 3; k++) begin
      if (k == 1 || k == 3) begin
        checks++; if (slot_init !== 2'b00) begin errors++; $display("FAIL single_init_k%0d: got %b expected 00", k, slot_init); end
      end
      if (k == 2) begin
        checks++; if (slot_init !== 2'b01) begin errors++; $display("FAIL single_init: got %b expected 01", slot_init); end
        checks++; if (slot_instr !== a) begin errors++; $display("FAIL single_instr: got %h expected %h", slot_instr, a); end
        checks++; if (slot_ctrl !== mk_ctrl()) begin errors++; $display("FAIL single_ctrl: got %h expected %h", slot_ctrl, mk_ctrl()); end
        checks++; if (issued_count !== 32'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", issued_count); end
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL single_idle_pulse: got %b expected 0", idle); end
      end
      if (k == 3) begin
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle_after: got %b expected 1", idle); end
      end
      in_valid = (k == 0); in_instr = a; in_ctrl = mk_ctrl();
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    decoded_vinstruction_t ins [3];
    logic [1:0] exp_init;
    for (int i = 0; i < 3; i++) ins[i] = mk_instr(5'(i + 8), 1'b0);
    do_reset();
    for (int k = 0; k <= 10; k++) begin
      exp_init = (k == 2 || k == 9) ? 2'b01 : (k == 3) ? 2'b10 : 2'b00;
      if (k >= 1) begin
        checks++; if (slot_init !== exp_init) begin errors++; $display("FAIL b2b_init_k%0d: got %b expected %b", k, slot_init, exp_init); end
      end
      if (k == 2 || k == 3 || k == 9) begin
        checks++; if (slot_instr !== ins[k == 9 ? 2 : k - 2]) begin errors++; $display("FAIL b2b_instr_k%0d: got %h", k, slot_instr); end
      end
      if (k == 9) begin
        checks++; if (issued_count !== 32'd3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", issued_count); end
      end
      in_valid = (k < 3); in_instr = ins[k < 3 ? k : 2]; in_ctrl = mk_ctrl();
      slot_active[0] = (k >= 3 && k <= 7);
      slot_active[1] = (k >= 4 && k <= 9);
      @(negedge clk);
    end
  endtask

  task automatic test_full();
    decoded_vinstruction_t ins [5];
    logic [1:0] exp_init;
    for (int i = 0; i < 5; i++) ins[i] = mk_instr(5'(i + 16), 1'b0);
    do_reset();
    for (int k = 0; k <= 10; k++) begin
      exp_init = (k == 5 || k == 7 || k == 9) ? 2'b01 : (k == 6 || k == 8) ? 2'b10 : 2'b00;
      checks++; if (slot_init !== exp_init) begin errors++; $display("FAIL full_init_k%0d: got %b expected %b", k, slot_init, exp_init); end
      if (k >= 5 && k <= 9) begin
        checks++; if (slot_instr !== ins[k - 5]) begin errors++; $display("FAIL full_order_k%0d: got %h expected %h", k, slot_instr, ins[k - 5]); end
      end
      if (k == 3 || k == 5) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_k%0d: got %b expected 1", k, in_ready); end
      end
      if (k == 4) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready_full: got %b expected 0", in_ready); end
      end
      if (k == 9) begin
        checks++; if (issued_count !== 32'd5) begin errors++; $display("FAIL full_count: got %0d expected 5", issued_count); end
      end
      if (k == 10) begin
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL full_idle: got %b expected 1", idle); end
      end
      in_valid = (k <= 5); in_instr = ins[k < 4 ? k : 4]; in_ctrl = mk_ctrl();
      slot_active = (k < 4) ? 2'b11 : 2'b00;
      @(negedge clk);
    end
  endtask

  task automatic test_serial();
    decoded_vinstruction_t st_i;
    decoded_vinstruction_t pl_i;
    logic [1:0] exp_init;
    st_i = mk_instr(5'd20, 1'b1);
    pl_i = mk_instr(5'd21, 1'b0);
    do_reset();
    for (int k = 0; k <= 10; k++) begin
      exp_init = (k == 6) ? 2'b01 : (k == 10) ? 2'b10 : 2'b00;
      checks++; if (slot_init !== exp_init) begin errors++; $display("FAIL ser_init_k%0d: got %b expected %b", k, slot_init, exp_init); end
      if (k == 6) begin
        checks++; if (slot_instr !== st_i) begin errors++; $display("FAIL ser_store_instr: got %h expected %h", slot_instr, st_i); end
      end
      if (k == 10) begin
        checks++; if (slot_instr !== pl_i) begin errors++; $display("FAIL ser_plain_instr: got %h expected %h", slot_instr, pl_i); end
        checks++; if (issued_count !== 32'd2) begin errors++; $display("FAIL ser_count: got %0d expected 2", issued_count); end
      end
      in_valid = (k <= 1); in_instr = (k == 0) ? st_i : pl_i; in_ctrl = mk_ctrl();
      slot_active = (k <= 4) ? 2'b10 : (k == 6 || k == 7) ? 2'b01 : 2'b00;
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    decoded_vinstruction_t a;
    logic [1:0] exp_init;
    a = mk_instr(5'd25, 1'b0);
    do_reset();
    for (int k = 0; k <= 6; k++) begin
      exp_init = (k == 5) ? 2'b01 : 2'b00;
      checks++; if (slot_init !== exp_init) begin errors++; $display("FAIL stall_init_k%0d: got %b expected %b", k, slot_init, exp_init); end
      in_valid = (k == 0); in_instr = a; in_ctrl = mk_ctrl();
      stall = (k >= 1 && k <= 3);
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    decoded_vinstruction_t ins [4];
    for (int i = 0; i < 4; i++) ins[i] = mk_instr(5'(i + 26), 1'b0);
    do_reset();
    for (int k = 0; k <= 9; k++) begin
      if (k == 5) begin
        checks++; if (slot_init !== 2'b01) begin errors++; $display("FAIL mid_pending: got %b expected 01", slot_init); end
      end
      if (k == 6) begin
        checks++; if (slot_instr !== '0) begin errors++; $display("FAIL mid_instr: got %h expected 0", slot_instr); end
        checks++; if (slot_ctrl !== '0) begin errors++; $display("FAIL mid_ctrl: got %h expected 0", slot_ctrl); end
        checks++; if (issued_count !== 32'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", issued_count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b expected 0", in_ready); end
      end
      if (k >= 6) begin
        checks++; if (slot_init !== 2'b00) begin errors++; $display("FAIL mid_init_k%0d: got %b expected 00", k, slot_init); end
      end
      if (k == 7) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_after: got %b expected 1", in_ready); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL mid_idle: got %b expected 1", idle); end
      end
      in_valid = (k < 4); in_instr = ins[k < 4 ? k : 3]; in_ctrl = mk_ctrl();
      rst = (k != 5);
      slot_active = (k < 4 || k == 5) ? 2'b11 : 2'b00;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_serial();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
